// File: rtl/mem_arbiter_if.sv
// Bundle of per-master request/response lanes and the single downstream memory port.
// The arbiter uses the slave modport; the driving environment uses the master modport.
interface mem_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 128
);
    logic [NUM_MASTERS-1:0]            m_strobe_i;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i;
    logic [NUM_MASTERS-1:0]            m_rw_i;
    logic [DATA_WIDTH-1:0]             m_rdata_o;
    logic [NUM_MASTERS-1:0]            m_done_o;
    logic                              mem_strobe_o;
    logic [ADDR_WIDTH-1:0]             mem_addr_o;
    logic [DATA_WIDTH-1:0]             mem_wdata_o;
    logic                              mem_rw_o;
    logic [DATA_WIDTH-1:0]             mem_rdata_i;
    logic                              mem_done_i;

    modport slave (
        input  m_strobe_i, m_addr_i, m_wdata_i, m_rw_i, mem_rdata_i, mem_done_i,
        output m_rdata_o, m_done_o, mem_strobe_o, mem_addr_o, mem_wdata_o, mem_rw_o
    );

    modport master (
        output m_strobe_i, m_addr_i, m_wdata_i, m_rw_i, mem_rdata_i, mem_done_i,
        input  m_rdata_o, m_done_o, mem_strobe_o, mem_addr_o, mem_wdata_o, mem_rw_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter merging NUM_MASTERS line requests onto one memory strobe/done port.
// Optional per-master grant/wait counters are enabled by defining MEM_ARBITER_STATS_EN.
module mem_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 128
) (
    input  logic clk,
    input  logic rst,
`ifdef MEM_ARBITER_STATS_EN
    output logic [NUM_MASTERS*32-1:0] stat_grants_o,
    output logic [NUM_MASTERS*32-1:0] stat_wait_o,
`endif
    mem_arbiter_if.slave bus
);
    localparam int unsigned GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] pending_q, pending_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic                   mem_rw_q, mem_rw_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [GW-1:0]          winner;
    logic [NUM_MASTERS-1:0] done_onehot;

    // First pending master searching upward from last_grant+1, wrapping.
    always_comb begin
        logic          found;
        int unsigned   idx;
        logic [GW-1:0] idx_g;
        winner = last_grant_q;
        found  = 1'b0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            idx   = (32'(last_grant_q) + i) % NUM_MASTERS;
            idx_g = GW'(idx);
            if (!found && pending_q[idx_g]) begin
                winner = idx_g;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rw_d     = mem_rw_q;
        rdata_d      = rdata_q;
        // Strobes on already-pending masters are absorbed by the OR; the WAIT clear wins.
        pending_d    = pending_q | bus.m_strobe_i;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    grant_d      = winner;
                    last_grant_d = winner;
                    mem_addr_d   = bus.m_addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_wdata_d  = bus.m_wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];
                    mem_rw_d     = bus.m_rw_i[winner];
                    state_d      = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.mem_done_i) begin
                    if (!mem_rw_q) rdata_d = bus.mem_rdata_i;
                    pending_d[grant_q] = 1'b0;
                    state_d            = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_MASTERS - 1);
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rw_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rw_q     <= mem_rw_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        done_onehot = '0;
        if (state_q == RESP) done_onehot[grant_q] = 1'b1;
    end

    assign bus.mem_strobe_o = (state_q == ISSUE);
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_wdata_o  = mem_wdata_q;
    assign bus.mem_rw_o     = mem_rw_q;
    assign bus.m_rdata_o    = rdata_q;
    assign bus.m_done_o     = done_onehot;

`ifdef MEM_ARBITER_STATS_EN
    logic [NUM_MASTERS-1:0][31:0] grants_q, grants_d;
    logic [NUM_MASTERS-1:0][31:0] waits_q, waits_d;

    // A master counts as waiting whenever its request is pending but it does not own the bus.
    always_comb begin
        grants_d = grants_q;
        waits_d  = waits_q;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (state_q == RESP && grant_q == GW'(k) && grants_q[k] != '1)
                grants_d[k] = grants_q[k] + 32'd1;
            if (pending_q[k] && !(state_q != IDLE && grant_q == GW'(k)) && waits_q[k] != '1)
                waits_d[k] = waits_q[k] + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grants_q <= '0;
            waits_q  <= '0;
        end else begin
            grants_q <= grants_d;
            waits_q  <= waits_d;
        end
    end

    assign stat_grants_o = grants_q;
    assign stat_wait_o   = waits_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized traffic,
// compared every cycle against a transaction-level round-robin reference model.
module tb_mem_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [AW-1:0] maddr  [N];
    logic [DW-1:0] mwdata [N];
    logic          mrw    [N];
    logic [N-1:0]  nxt_strobe, drv_strobe, auto_restrobe;
    logic          drv_mdone;

    logic [N-1:0]  pend, prev_pend, exp_done;
    logic [DW-1:0] exp_rdata, mem_line, force_line;
    logic          force_en;
    logic [AW-1:0] req_addr  [N];
    logic [DW-1:0] req_wdata [N];
    logic          req_rw    [N];
    logic [AW-1:0] last_addr;
    int last_grant, cur, last_done, mcnt, lat_fixed, stall;
    int strobes = 0, dones = 0, accepted = 0;
    int order[$];
    bit rand_en = 1'b0;

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(logic [N-1:0] p, int last);
        for (int i = 1; i <= N; i++)
            if (p[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    task automatic model_reset();
        pend = '0; prev_pend = '0; exp_done = '0; exp_rdata = '0;
        last_grant = N - 1; cur = -1; last_done = -100; mcnt = -1; stall = 0;
        drv_strobe = '0; drv_mdone = 1'b0; nxt_strobe = '0; auto_restrobe = '0;
        last_addr = '0;
    endtask

    task automatic drive_bus();
        bus.m_strobe_i  = drv_strobe;
        bus.mem_done_i  = drv_mdone;
        bus.mem_rdata_i = drv_mdone ? mem_line : {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < N; k++) begin
            bus.m_addr_i[k*AW +: AW]  = maddr[k];
            bus.m_wdata_i[k*DW +: DW] = mwdata[k];
            bus.m_rw_i[k]             = mrw[k];
        end
    endtask

    // One clock cycle: apply last edge to the model, check outputs, then drive new inputs.
    task automatic tick();
        logic [N-1:0] st;
        int w;
        @(negedge clk);
        cyc++;
        prev_pend = pend;
        exp_done  = '0;
        if (drv_mdone && cur >= 0) begin
            pend[cur]     = 1'b0;
            exp_done[cur] = 1'b1;
            if (!req_rw[cur]) exp_rdata = mem_line;
            last_done = cyc - 1;
            cur = -1;
            dones++;
        end
        for (int k = 0; k < N; k++) begin
            if (drv_strobe[k] && !prev_pend[k]) begin
                pend[k] = 1'b1;
                req_addr[k] = maddr[k]; req_wdata[k] = mwdata[k]; req_rw[k] = mrw[k];
                accepted++;
            end
        end
        chk("m_done", DW'(bus.m_done_o), DW'(exp_done));
        chk("m_rdata", bus.m_rdata_o, exp_rdata);

        drv_mdone = 1'b0;
        if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin drv_mdone = 1'b1; mcnt = -1; end
        end

        if (bus.mem_strobe_o === 1'b1) begin
            strobes++;
            w = rr_pick(prev_pend, last_grant);
            chk("strobe_while_busy", DW'(cur < 0), DW'(1));
            chk("strobe_gap", DW'(cyc - last_done >= 2), DW'(1));
            chk("strobe_has_request", DW'(w >= 0), DW'(1));
            if (w >= 0) begin
                chk("mem_rw", DW'(bus.mem_rw_o), DW'(req_rw[w]));
                if (req_rw[w]) chk("mem_wdata", bus.mem_wdata_o, req_wdata[w]);
                last_grant = w;
                last_addr  = req_addr[w];
                order.push_back(w);
            end
            cur = w;
            mcnt = (lat_fixed > 0) ? lat_fixed : $urandom_range(1, 6);
            mem_line = force_en ? force_line : {$urandom, $urandom, $urandom, $urandom};
            stall = 0;
        end else if (cur < 0 && pend != '0) begin
            stall++;
            chk("issue_stall", DW'(stall <= 4), DW'(1));
            if (stall > 4) stall = 0;
        end else begin
            stall = 0;
        end
        chk("mem_addr", DW'(bus.mem_addr_o), DW'(last_addr));

        st = nxt_strobe;
        nxt_strobe = '0;
        for (int k = 0; k < N; k++) begin
            if (auto_restrobe[k] && exp_done[k]) begin
                st[k] = 1'b1;
                auto_restrobe[k] = 1'b0;
            end
            if (rand_en) begin
                if (!pend[k] && $urandom_range(0, 3) == 0) begin
                    maddr[k]  = $urandom;
                    mwdata[k] = {$urandom, $urandom, $urandom, $urandom};
                    mrw[k]    = 1'($urandom_range(0, 1));
                    st[k]     = 1'b1;
                end else if (pend[k] && $urandom_range(0, 7) == 0) begin
                    st[k] = 1'b1;
                end
            end
        end
        drv_strobe = st;
        drive_bus();
        // Spurious done while nothing is outstanding must be ignored.
        if (rand_en && !drv_mdone && cur < 0 && mcnt < 0 && $urandom_range(0, 9) == 0) begin
            drv_mdone = 1'b1;
            bus.mem_done_i = 1'b1;
        end
    endtask

    task automatic do_reset(bit check);
        #2 rst = 1'b1;
        #1;
        if (check) begin
            chk("rst_mem_strobe", DW'(bus.mem_strobe_o), DW'(0));
            chk("rst_m_done", DW'(bus.m_done_o), DW'(0));
            chk("rst_mem_addr", DW'(bus.mem_addr_o), DW'(0));
            chk("rst_m_rdata", bus.m_rdata_o, DW'(0));
        end
        model_reset();
        drive_bus();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_idle(int budget);
        int i = 0;
        do begin
            tick();
            i++;
        end while (!(pend == '0 && cur < 0 && drv_strobe == '0) && i < budget);
        chk("drain", DW'(pend == '0 && cur < 0), DW'(1));
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s, s0, d0, a0;
        for (int k = 0; k < N; k++) begin
            maddr[k] = '0; mwdata[k] = '0; mrw[k] = 1'b0;
        end
        force_en = 1'b0; force_line = '0; lat_fixed = 5; mem_line = '0;
        model_reset();
        drive_bus();
        do_reset(1'b1);

        // Single read, L=5: done expected L+3 cycles after the strobe.
        force_en = 1'b1; force_line = {16{8'hA5}};
        maddr[0] = 32'h8000_0100; mrw[0] = 1'b0;
        s0 = strobes;
        nxt_strobe = 2'b01;
        tick();
        s = cyc;
        for (int i = 0; i < 20 && bus.m_done_o == '0; i++) tick();
        chk("read_latency", DW'(cyc - s), DW'(8));
        chk("read_done", DW'(bus.m_done_o), DW'(2'b01));
        chk("read_data", bus.m_rdata_o, {16{8'hA5}});
        run_idle(30);
        chk("read_one_strobe", DW'(strobes - s0), DW'(1));

        // Single write from master 1 leaves the returned line untouched.
        maddr[1] = 32'h8000_0200; mrw[1] = 1'b1;
        mwdata[1] = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        d0 = dones;
        nxt_strobe = 2'b10;
        tick();
        run_idle(30);
        chk("write_one_done", DW'(dones - d0), DW'(1));
        chk("write_keeps_rdata", bus.m_rdata_o, {16{8'hA5}});
        force_en = 1'b0;

        // Simultaneous strobes after reset: 0 then 1, and again 0 then 1.
        do_reset(1'b0);
        maddr[0] = 32'h8000_1000; mrw[0] = 1'b0;
        maddr[1] = 32'h8000_2000; mrw[1] = 1'b0;
        for (int r = 0; r < 2; r++) begin
            order.delete();
            nxt_strobe = 2'b11;
            tick();
            run_idle(60);
            chk("simul_count", DW'(order.size()), DW'(2));
            if (order.size() == 2) begin
                chk("simul_first", DW'(order[0]), DW'(0));
                chk("simul_second", DW'(order[1]), DW'(1));
            end
        end

        // Three queued requests: master 0 re-strobes in its own RESP cycle.
        order.delete();
        d0 = dones;
        lat_fixed = 3;
        auto_restrobe = 2'b01;
        nxt_strobe = 2'b11;
        tick();
        run_idle(100);
        chk("b2b_dones", DW'(dones - d0), DW'(3));
        chk("b2b_count", DW'(order.size()), DW'(3));
        if (order.size() == 3) chk("b2b_third", DW'(order[2]), DW'(0));

        // Repeated strobes while pending collapse into one transaction.
        s0 = strobes;
        for (int i = 0; i < 3; i++) begin
            nxt_strobe = 2'b01;
            tick();
        end
        run_idle(40);
        chk("restrobe_ignored", DW'(strobes - s0), DW'(1));

        // Asynchronous reset in WAIT aborts everything.
        lat_fixed = 6;
        nxt_strobe = 2'b01;
        tick();
        for (int i = 0; i < 10 && cur < 0; i++) tick();
        chk("reach_issue", DW'(cur >= 0), DW'(1));
        tick();
        tick();
        do_reset(1'b1);
        s0 = strobes;
        repeat (15) tick();
        chk("quiet_after_reset", DW'(strobes - s0), DW'(0));

        // Randomized traffic with random latencies and spurious dones.
        lat_fixed = 0;
        a0 = accepted;
        d0 = dones;
        rand_en = 1'b1;
        repeat (3000) tick();
        rand_en = 1'b0;
        run_idle(200);
        chk("random_all_completed", DW'(accepted - a0), DW'(dones - d0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter that merges NUM_MASTERS per-core line requests (D-cache/I-cache miss engines in the multi-core build) onto the single dmem strobe/done port of the simulation main memory.
- Accepts a one-cycle strobe per request and issues exactly one downstream transaction at a time.
- Returns the 128-bit line and a one-cycle done pulse to the requesting master only.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 128, line width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m_strobe_i  in  NUM_MASTERS  per-master request pulse
- m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  request addresses; master k uses slice [k*ADDR_WIDTH +: ADDR_WIDTH]
- m_wdata_i  in  NUM_MASTERS*DATA_WIDTH  write lines, sliced the same way
- m_rw_i  in  NUM_MASTERS  1 = write, 0 = read
- m_rdata_o  out  DATA_WIDTH  returned read line, shared by all masters
- m_done_o  out  NUM_MASTERS  one-hot completion pulse
- mem_strobe_o  out  1  downstream request
- mem_addr_o  out  ADDR_WIDTH  downstream address
- mem_wdata_o  out  DATA_WIDTH  downstream write line
- mem_rw_o  out  1  downstream direction
- mem_rdata_i  in  DATA_WIDTH  downstream read line, valid in the cycle mem_done_i=1
- mem_done_i  in  1  downstream completion, high for one cycle

Behaviour:
- Reset (async, rst=1): all outputs 0, pending=0, state=IDLE, last_grant=NUM_MASTERS-1.
- Request capture: pending[k] is set at a clock edge where m_strobe_i[k]=1. A strobe while pending[k]=1 is ignored. Master k must keep m_addr_i/m_wdata_i/m_rw_i stable from its strobe until its done pulse.
- Arbitration: round-robin. Search starts at last_grant+1 and wraps at NUM_MASTERS. The first pending master wins.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any pending bit is set, latch grant and register the winner's addr/wdata/rw into mem_*_o, update last_grant, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: mem_strobe_o=1 for exactly this cycle, then go to WAIT.
  - WAIT: mem_strobe_o=0. On mem_done_i=1, capture m_rdata_o<=mem_rdata_i (reads only; writes leave m_rdata_o unchanged), clear pending[grant], go to RESP.
  - RESP: m_done_o = one-hot(grant) for this cycle only, go to IDLE.
- Latency, uncontended, downstream latency L cycles from strobe to done: m_done_o rises L+3 cycles after m_strobe_i.
- Back-to-back: the next mem_strobe_o is at least 2 cycles after mem_done_i. This guarantees the downstream memory has passed through its DONE state back to IDLE.
- Simultaneous strobes: all pending bits are set in the same edge. Service order follows round-robin from last_grant+1.
- A master may strobe again in its own RESP cycle. The new request is accepted, since pending was already cleared at the WAIT->RESP edge.
- mem_addr_o/mem_wdata_o/mem_rw_o hold their values outside ISSUE/WAIT (no glitching to 0).
- mem_done_i outside WAIT is ignored.
- Reset mid-transaction aborts everything. Downstream memory is reset in the same system reset, so no orphan done can arrive.

Optional Feature:
- Macro: MEM_ARBITER_STATS_EN.
- When defined, adds outputs:
  - stat_grants_o (NUM_MASTERS*32): per-master count of completed transactions, incremented in RESP.
  - stat_wait_o (NUM_MASTERS*32): per-master count of cycles with pending=1 while not granted.
  - Both are cleared by rst and saturate at 32'hFFFFFFFF.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single read:
  - Stimulus: m_strobe_i=2'b01, addr0=32'h8000_0100, rw=0, memory model L=5 returning 128'hA5A5...; check at cycle 0.
  - Response: one mem_strobe_o pulse with mem_addr_o=32'h8000_0100; m_done_o=2'b01 at cycle 8; m_rdata_o=128'hA5A5...
- Single write:
  - Stimulus: master 1, addr 32'h8000_0200, rw=1, wdata 128'h1122...EEFF.
  - Response: mem_rw_o=1 and mem_wdata_o matches during ISSUE; m_done_o=2'b10 once; m_rdata_o unchanged.
- Simultaneous requests:
  - Stimulus: m_strobe_i=2'b11 right after reset.
  - Response: master 0 served first, then master 1. Repeat with 2'b11: master 0 first again (last_grant=1).
- Back-to-back gap:
  - Stimulus: three queued requests.
  - Response: every mem_strobe_o is >=2 cycles after the previous mem_done_i; exactly three done pulses, one per request.
- Re-strobe and ignore:
  - Stimulus: master 0 strobes twice while pending.
  - Response: only one downstream transaction. Master 0 strobing in its RESP cycle yields a second transaction.
- Async reset mid-WAIT:
  - Stimulus: assert rst between clock edges.
  - Response: mem_strobe_o, m_done_o, pending are 0 immediately; after release with no strobes, no downstream activity.
